oh_lgate_pipe: RTL and testbench
================================

Name: oh_lgate_pipe

Overview:
Parametrised, pipelined multi-input logic gate: the registered successor of the single-bit two-input NAND cell. Reduces N input vectors of DW bits bitwise with a run-time selectable function (NAND/NOR/AND/OR/XOR/XNOR/INV). Result passes through STAGES elastic register stages with valid/ready flow control. Used as a characterisable, synthesizable logic-cell exerciser and as a generic registered gate in datapaths.

Parameters:
N, 2, number of input operands (2..8)
DW, 1, bit width of each operand and of the result (>=1)
STAGES, 1, register stages between input and output (1..8)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous active-high reset
mode  input  3  function select, sampled with each accepted input beat
in_valid  input  1  input beat valid
in_ready  output  1  block can accept a beat this cycle
in_data  input  N*DW  operands; operand k = in_data[k*DW +: DW]
out_valid  output  1  out_data holds a valid result
out_ready  input  1  downstream accepts result this cycle
out_data  output  DW  result of head beat
level  output  4  number of valid stages occupied (0..STAGES)
err  output  1  sticky: a beat with a reserved mode was accepted

Behaviour:
- Reset (async assert, sync-to-clk deassert not required inside block): all stage valid bits 0, stage data 0, out_valid=0, out_data=0, level=0, err=0; in_ready=1 one delta after reset deasserts.
- Accept: input beat transfers when in_valid & in_ready on rising clk. Output transfers when out_valid & out_ready.
- Function applied combinationally at input, result registered into stage 0:
  0 NAND ~(&ops), 1 NOR ~(|ops), 2 AND, 3 OR, 4 XOR (odd parity per bit), 5 XNOR, 6 INV ~op0 (other operands ignored), 7 reserved -> result all zeros, err set on the same edge, sticky until reset.
- Mode is captured per beat; changing mode never affects beats already in flight.
- Elastic pipeline: stage i loads from stage i-1 (or input for i=0) when stage i is empty or stage i advances this cycle. in_ready = ~valid[0] | advance[0]; advance[last] = out_ready. Bubbles collapse: a stalled output lets upstream empty stages fill.
- Latency: STAGES cycles from accept to out_valid with out_ready held 1. Throughput: 1 beat/cycle sustained.
- Full: all STAGES valid and out_ready=0 -> in_ready=0, data held stable, out_data/out_valid unchanged until accepted.
- Empty: level=0, out_valid=0, out_data holds last value (not cleared).
- Simultaneous accept and emit while full: both occur, level unchanged.
- level increments on accept-only, decrements on emit-only, unchanged otherwise; never exceeds STAGES.
- Reset mid-operation: all in-flight beats discarded, no partial output.

Optional Feature:
OH_LGATE_PIPE_PARITY_EN: when defined, extra output out_parity (1 bit) = even parity (^) of the result, computed at input and carried alongside data through every stage, valid with out_valid, reset to 0. When undefined, port and parity registers are absent; all other behaviour identical.

Test Plan:
- N=2 DW=4 STAGES=2, out_ready=1, mode=0, in_data={4'b1010,4'b1100} one beat -> out_valid high exactly 2 cycles later, out_data=4'b0111, level returns to 0.
- Sweep modes 0..6 back-to-back with ops 4'b1100/4'b1010 -> outputs 0111,0001,1000,1110,0110,1001,0011 on consecutive cycles, err stays 0.
- Backpressure: out_ready=0, push 3 beats with STAGES=2 -> first two accepted, in_ready=0 on third, level=2; raise out_ready -> results emerge in order, no loss/duplication.
- Reserved mode=7 beat -> out_data=4'b0000, err=1 and stays 1 after subsequent valid beats; clears only on reset.
- Assert reset with level=2 mid-stream -> out_valid=0, level=0, err=0 immediately (asynchronous), no stale beat emitted after release.
- With OH_LGATE_PIPE_PARITY_EN, XOR of 4'b1100/4'b1010 -> out_data=4'b0110, out_parity=0; NAND of same -> 4'b0111, out_parity=1.

Source files
------------

// File: rtl/oh_lgate_pipe_if.sv
// oh_lgate_pipe_if: operand/result handshake bundle for oh_lgate_pipe.
// The master side drives operands and accepts results. The slave side is the gate pipeline.
// The out_parity signal exists only when OH_LGATE_PIPE_PARITY_EN is defined.
interface oh_lgate_pipe_if #(
  parameter int N  = 2,
  parameter int DW = 1
);
  logic [2:0]      mode;
  logic            in_valid;
  logic            in_ready;
  logic [N*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [DW-1:0]   out_data;
  logic [3:0]      level;
  logic            err;
`ifdef OH_LGATE_PIPE_PARITY_EN
  logic            out_parity;
`endif

  modport master (
`ifdef OH_LGATE_PIPE_PARITY_EN
    input  out_parity,
`endif
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, level, err
  );

  modport slave (
`ifdef OH_LGATE_PIPE_PARITY_EN
    output out_parity,
`endif
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, level, err
  );
endinterface

// File: rtl/oh_lgate_pipe.sv
// oh_lgate_pipe: N-operand bitwise gate (NAND/NOR/AND/OR/XOR/XNOR/INV) whose result
// travels through STAGES elastic valid/ready register stages.
// Optional feature macro: OH_LGATE_PIPE_PARITY_EN. When it is defined, the even parity
// of each result is carried alongside the data and driven on out_parity.
module oh_lgate_pipe #(
  parameter int N      = 2,
  parameter int DW     = 1,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             reset,
  oh_lgate_pipe_if.slave   bus
);

  localparam logic [2:0] MODE_RSVD = 3'd7;

  // Reduce all operands bitwise with the selected function. The reserved mode yields zero.
  function automatic logic [DW-1:0] gate_fn(input logic [2:0] m, input logic [N*DW-1:0] d);
    logic [DW-1:0] and_v;
    logic [DW-1:0] or_v;
    logic [DW-1:0] xor_v;
    and_v = {DW{1'b1}};
    or_v  = {DW{1'b0}};
    xor_v = {DW{1'b0}};
    for (int k = 0; k < N; k++) begin
      and_v = and_v & d[k*DW +: DW];
      or_v  = or_v  | d[k*DW +: DW];
      xor_v = xor_v ^ d[k*DW +: DW];
    end
    case (m)
      3'd0:    gate_fn = ~and_v;
      3'd1:    gate_fn = ~or_v;
      3'd2:    gate_fn = and_v;
      3'd3:    gate_fn = or_v;
      3'd4:    gate_fn = xor_v;
      3'd5:    gate_fn = ~xor_v;
      3'd6:    gate_fn = ~d[DW-1:0];
      default: gate_fn = {DW{1'b0}};
    endcase
  endfunction

  // Even parity of one result word.
  function automatic logic even_parity(input logic [DW-1:0] x);
    even_parity = ^x;
  endfunction

  logic [STAGES-1:0] valid_r;
  logic [DW-1:0]     data_r [STAGES];
  logic [3:0]        level_r;
  logic              err_r;
  logic [STAGES-1:0] load_s;
  logic [DW-1:0]     result_s;
  logic              accept_s;
  logic              emit_s;
`ifdef OH_LGATE_PIPE_PARITY_EN
  logic [STAGES-1:0] parity_r;
`endif

  // Stage i may load when it or any downstream stage is empty, or when the output drains.
  // Writing this out per stage avoids a combinational chain through load_s itself.
  always_comb begin
    load_s = {STAGES{1'b0}};
    for (int i = 0; i < STAGES; i++) begin
      load_s[i] = bus.out_ready;
      for (int j = i; j < STAGES; j++) begin
        load_s[i] = load_s[i] | ~valid_r[j];
      end
    end
  end

  // Apply the gate function to the incoming beat and derive the handshake strobes.
  always_comb begin
    result_s = gate_fn(bus.mode, bus.in_data);
    accept_s = bus.in_valid & load_s[0];
    emit_s   = valid_r[STAGES-1] & bus.out_ready;
  end

  // Elastic stage registers. Data moves only with a valid beat, so out_data holds its
  // value while the pipeline is empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= {STAGES{1'b0}};
      for (int i = 0; i < STAGES; i++) begin
        data_r[i] <= {DW{1'b0}};
      end
    end else begin
      if (load_s[0]) begin
        valid_r[0] <= bus.in_valid;
        if (bus.in_valid) begin
          data_r[0] <= result_s;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (load_s[i]) begin
          valid_r[i] <= valid_r[i-1];
          if (valid_r[i-1]) begin
            data_r[i] <= data_r[i-1];
          end
        end
      end
    end
  end

`ifdef OH_LGATE_PIPE_PARITY_EN
  // The parity bit travels with its data word through every stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity_r <= {STAGES{1'b0}};
    end else begin
      if (load_s[0] && bus.in_valid) begin
        parity_r[0] <= even_parity(result_s);
      end
      for (int i = 1; i < STAGES; i++) begin
        if (load_s[i] && valid_r[i-1]) begin
          parity_r[i] <= parity_r[i-1];
        end
      end
    end
  end

  assign bus.out_parity = parity_r[STAGES-1];
`endif

  // Occupancy counter. It rises on accept-only and falls on emit-only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_r <= 4'd0;
    end else begin
      case ({accept_s, emit_s})
        2'b10:   level_r <= level_r + 4'd1;
        2'b01:   level_r <= level_r - 4'd1;
        default: level_r <= level_r;
      endcase
    end
  end

  // Sticky flag set when a beat carrying the reserved mode is accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else if (accept_s && (bus.mode == MODE_RSVD)) begin
      err_r <= 1'b1;
    end
  end

  assign bus.in_ready  = load_s[0];
  assign bus.out_valid = valid_r[STAGES-1];
  assign bus.out_data  = data_r[STAGES-1];
  assign bus.level     = level_r;
  assign bus.err       = err_r;

endmodule

// File: tb/tb_oh_lgate_pipe.sv
// tb_oh_lgate_pipe: self-checking bench for oh_lgate_pipe with N=2, DW=4 and STAGES=2.
// Expected results are queued as each beat is accepted. They are then compared, in order,
// as the beats leave the pipeline.
module tb_oh_lgate_pipe;
  localparam int N      = 2;
  localparam int DW     = 4;
  localparam int STAGES = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  oh_lgate_pipe_if #(.N(N), .DW(DW)) bus ();

  oh_lgate_pipe #(.N(N), .DW(DW), .STAGES(STAGES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] d;
    logic       p;
  } exp_t;

  typedef struct {
    logic [2:0] mode;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] exp_d;
  } vec_t;

  exp_t sb_q[$];
  int   cmp_cnt  = 0;
  int   mis_cnt  = 0;
  int   emit_cnt = 0;
  int   acc_cnt  = 0;
  int   cyc      = 0;
  bit   stop_tog = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference gate evaluated bit by bit from a count of ones. op1 = a and op0 = b.
  function automatic logic [3:0] model(input logic [2:0] m, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] r;
    for (int j = 0; j < 4; j++) begin
      int ones;
      ones = int'(a[j]) + int'(b[j]);
      case (m)
        3'd0:    r[j] = (ones != 2);
        3'd1:    r[j] = (ones == 0);
        3'd2:    r[j] = (ones == 2);
        3'd3:    r[j] = (ones != 0);
        3'd4:    r[j] = (ones == 1);
        3'd5:    r[j] = (ones != 1);
        3'd6:    r[j] = ~b[j];
        default: r[j] = 1'b0;
      endcase
    end
    return r;
  endfunction

  // Output monitor. A transfer happens at the next rising edge, so compare now, mid-cycle.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      exp_t e;
      emit_cnt++;
      if (sb_q.size() == 0) begin
        cmp_cnt++;
        mis_cnt++;
        $display("FAIL unexpected_emit: out_data %0h with no beat outstanding", bus.out_data);
      end else begin
        e = sb_q.pop_front();
        check("out_data", {28'd0, bus.out_data}, {28'd0, e.d});
`ifdef OH_LGATE_PIPE_PARITY_EN
        check("out_parity", {31'd0, bus.out_parity}, {31'd0, e.p});
`endif
      end
    end
  end

  // Present one beat and hold it until it is accepted. Call it just after a rising edge.
  task automatic push(input logic [2:0] m, input logic [3:0] a, input logic [3:0] b,
                      input logic [3:0] exp_d);
    int tries;
    bit ok;
    tries = 0;
    ok = 1'b0;
    bus.mode     = m;
    bus.in_data  = {a, b};
    bus.in_valid = 1'b1;
    while (!ok && tries < 200) begin
      @(negedge clk);
      ok = bus.in_ready;
      if (ok) begin
        sb_q.push_back('{d: exp_d, p: ^exp_d});
        acc_cnt++;
      end
      @(posedge clk);
      #1;
      tries++;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      cmp_cnt++;
      mis_cnt++;
      $display("FAIL push_timeout: in_ready %0b, expected 1 within 200 cycles", bus.in_ready);
    end
  endtask

  // Wait, with a bound, for every outstanding beat to leave. Then check that the pipeline is empty.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(posedge clk);
    #1;
    check({name, "_outstanding"}, sb_q.size(), 32'd0);
    check({name, "_level"}, {28'd0, bus.level}, 32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    int e0;
    int c0;
    int a0;

    vecs[0] = '{3'd0, 4'b1010, 4'b1100, 4'b0111};
    vecs[1] = '{3'd1, 4'b1010, 4'b1100, 4'b0001};
    vecs[2] = '{3'd2, 4'b1010, 4'b1100, 4'b1000};
    vecs[3] = '{3'd3, 4'b1010, 4'b1100, 4'b1110};
    vecs[4] = '{3'd4, 4'b1010, 4'b1100, 4'b0110};
    vecs[5] = '{3'd5, 4'b1010, 4'b1100, 4'b1001};
    vecs[6] = '{3'd6, 4'b1010, 4'b1100, 4'b0011};

    bus.mode      = 3'd0;
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.out_ready = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_level", {28'd0, bus.level}, 32'd0);
    check("rst_err", {31'd0, bus.err}, 32'd0);
    check("rst_out_data", {28'd0, bus.out_data}, 32'd0);

    // A single NAND beat appears exactly STAGES cycles after it is driven.
    push(3'd0, 4'b1010, 4'b1100, 4'b0111);
    @(negedge clk);
    check("lat_valid_c1", {31'd0, bus.out_valid}, 32'd0);
    check("lat_level_c1", {28'd0, bus.level}, 32'd1);
    @(negedge clk);
    check("lat_valid_c2", {31'd0, bus.out_valid}, 32'd1);
    @(negedge clk);
    check("lat_valid_c3", {31'd0, bus.out_valid}, 32'd0);
    check("lat_level_c3", {28'd0, bus.level}, 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back sweep of modes 0..6, one beat per cycle.
    e0 = emit_cnt;
    c0 = cyc;
    for (int i = 0; i < 7; i++) begin
      push(vecs[i].mode, vecs[i].a, vecs[i].b, vecs[i].exp_d);
    end
    check("sweep_cycles", cyc - c0, 32'd7);
    drain("sweep");
    check("sweep_emits", emit_cnt - e0, 32'd7);
    check("sweep_err", {31'd0, bus.err}, 32'd0);

    // Backpressure: two beats fill the pipeline and the third must wait.
    e0 = emit_cnt;
    bus.out_ready = 1'b0;
    push(3'd2, 4'b1010, 4'b1100, 4'b1000);
    push(3'd3, 4'b1010, 4'b1100, 4'b1110);
    bus.mode     = 3'd4;
    bus.in_data  = {4'b1010, 4'b1100};
    bus.in_valid = 1'b1;
    @(negedge clk);
    check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    check("full_level", {28'd0, bus.level}, 32'd2);
    check("full_out_valid", {31'd0, bus.out_valid}, 32'd1);
    repeat (3) @(negedge clk);
    check("full_hold_data", {28'd0, bus.out_data}, 32'h8);
    check("full_hold_ready", {31'd0, bus.in_ready}, 32'd0);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    push(3'd4, 4'b1010, 4'b1100, 4'b0110);
    drain("bp");
    check("bp_emits", emit_cnt - e0, 32'd3);

    // A beat with the reserved mode gives zero and a sticky err flag.
    push(3'd7, 4'b1010, 4'b1100, 4'b0000);
    drain("rsvd");
    check("rsvd_err", {31'd0, bus.err}, 32'd1);
    push(3'd3, 4'b1010, 4'b1100, 4'b1110);
    push(3'd6, 4'b1010, 4'b1100, 4'b0011);
    drain("rsvd_after");
    check("rsvd_err_sticky", {31'd0, bus.err}, 32'd1);

    // Asynchronous reset while the pipeline is full.
    bus.out_ready = 1'b0;
    push(3'd0, 4'b1111, 4'b0000, 4'b1111);
    push(3'd1, 4'b1111, 4'b0000, 4'b0000);
    @(negedge clk);
    check("mid_level_pre", {28'd0, bus.level}, 32'd2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_level", {28'd0, bus.level}, 32'd0);
    check("mid_err", {31'd0, bus.err}, 32'd0);
    sb_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    e0 = emit_cnt;
    repeat (6) @(posedge clk);
    #1;
    check("mid_no_stale", emit_cnt - e0, 32'd0);

    // Random operands and modes while out_ready toggles at random.
    e0 = emit_cnt;
    a0 = acc_cnt;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [2:0] m;
          logic [3:0] a;
          logic [3:0] b;
          m = 3'($urandom_range(0, 6));
          a = 4'($urandom_range(0, 15));
          b = 4'($urandom_range(0, 15));
          push(m, a, b, model(m, a, b));
        end
        stop_tog = 1'b1;
      end
      begin
        int n;
        n = 0;
        while (!stop_tog && n < 2000) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
          n++;
        end
      end
    join
    bus.out_ready = 1'b1;
    drain("rand");
    check("rand_accepts", acc_cnt - a0, 32'd40);
    check("rand_emits", emit_cnt - e0, 32'd40);
    check("rand_err", {31'd0, bus.err}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

  // Watchdog that stops a run which would otherwise hang.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
